// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks stim 0..2^N_IN-1, holds each vector HOLD cycles,
// compares dut_y against exp_y on the last hold cycle. Optional macro: SWEEP_STOP_ON_ERR_EN.
module truth_table_sweeper #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 1,
  parameter int HOLD  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  dut_y,
  input  logic [N_OUT-1:0]  exp_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_vec,
  output logic [1:0]        dbg_state_o
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;

  logic mismatch;
  logic stop_on_err;

  assign mismatch = (dut_y != exp_y);

`ifdef SWEEP_STOP_ON_ERR_EN
  assign stop_on_err = mismatch;
`else
  assign stop_on_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (hold_q == HOLD_LAST) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) first_d = stim_q;
          end
          // pass is decided on the way into DONE so it is visible during the done pulse
          if (stop_on_err || stim_q == STIM_LAST) begin
            state_d = S_DONE;
            pass_d  = !mismatch && (err_q == '0);
          end else begin
            stim_d = stim_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stim          = stim_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: golden model differs from the DUT on a per-vector mask;
// expected sweep results are queued at start and compared when done pulses.
module tb_truth_table_sweeper;

  localparam int N_IN  = 5;
  localparam int N_OUT = 1;
  localparam int HOLD  = 10;
  localparam int NV    = 1 << N_IN;
  localparam int W     = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] dut_y;
  logic [N_OUT-1:0] exp_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic [N_IN-1:0]  first_err_vec;
  logic [1:0]       dbg_state;

  logic [31:0]      flip_mask = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .stim(stim), .dut_y(dut_y), .exp_y(exp_y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec),
    .dbg_state_o(dbg_state)
  );

  // Lab block under test is a parity gate; the golden model flips on masked vectors.
  assign dut_y = ^stim;
  assign exp_y = dut_y ^ flip_mask[stim];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stim"},  32'(stim), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_pass"},  32'(pass), 0);
    check({tag, "_err"},   32'(err_count), 0);
    check({tag, "_first"}, 32'(first_err_vec), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // Reference model of one sweep: {len, err, first, pass, final_stim}
  task automatic push_expected(input logic [31:0] mask);
    int err, first, fstim, len;
    logic ps;
    err = 0; first = 0; fstim = NV - 1; len = NV * HOLD;
    for (int v = 0; v < NV; v++) begin
      if (mask[v]) begin
        err++;
        if (err == 1) first = v;
`ifdef SWEEP_STOP_ON_ERR_EN
        fstim = v;
        len = (v + 1) * HOLD;
        break;
`endif
      end
    end
    ps = (err == 0);
    exp_q.push_back({7'd0, 16'(len), 6'(err), 5'(first), ps, 5'(fstim)});
  endtask

  // driver + monitor for one sweep; poke_at pulses start mid-run, abort_at asserts reset
  task automatic run_sweep(input logic [31:0] mask, input int poke_at, input int abort_at);
    int cnt;
    logic [W-1:0] e;
    flip_mask = mask;
    if (abort_at < 0) push_expected(mask);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_rise", 32'(busy), 1);
    cnt = 0;
    while (busy && cnt < 4000) begin
      check("stim_step", 32'(stim), 32'(cnt / HOLD));
      if (cnt == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_resume_busy", 32'(busy), 0);
        check("no_resume_stim", 32'(stim), 0);
        return;
      end
      if (cnt == poke_at) start = 1'b1;
      if (cnt == poke_at + 1) start = 1'b0;
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check("sweep_timeout", 32'(busy), 0);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("busy_len",      32'(cnt),           32'(e[32:17]));
    check("done_pulse",    32'(done),          1);
    check("err_count",     32'(err_count),     32'(e[16:11]));
    check("first_err_vec", 32'(first_err_vec), 32'(e[10:6]));
    check("pass",          32'(pass),          32'(e[5]));
    check("final_stim",    32'(stim),          32'(e[4:0]));
    @(negedge clk);
    check("done_clear",    32'(done),          0);
    check("idle_busy",     32'(busy),          0);
    check("stim_kept",     32'(stim),          32'(e[4:0]));
    check("pass_kept",     32'(pass),          32'(e[5]));
    repeat (3) @(negedge clk);
    check("single_done",   32'(done),          0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_sweep(32'h0000_0000, -1, -1);
    run_sweep(32'h0000_0008, -1, -1);
    run_sweep(32'hFFFF_FFFF, -1, -1);
    run_sweep(32'h0000_0000, -1, 7 * HOLD);
    run_sweep(32'h0000_0000, -1, -1);
    run_sweep(32'h0000_0000, 50, -1);
    run_sweep(32'h0000_0208, -1, -1);
    run_sweep(32'h8000_0000, -1, -1);
    for (int i = 0; i < 2; i++) run_sweep($urandom, -1, -1);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking exhaustive stimulus engine for small combinational lab blocks. On `start` it walks every input vector from 0 to 2^N_IN−1 and holds each one for a programmable number of cycles. On the last hold cycle of each vector it compares the DUT output with a golden-model output, then reports the mismatch count, the first failing vector and a pass flag. It sits in the bench/board harness in place of hand-written stimulus sequences, driving the DUT inputs and the golden model in parallel.

## Interface
Parameters:
- `N_IN`, default 5: number of DUT inputs; the sweep covers 2^N_IN vectors; legal range 1..16.
- `N_OUT`, default 1: number of DUT outputs compared.
- `HOLD`, default 10: clock cycles each vector is held; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle request to begin a sweep; honoured only in IDLE.
- `stim`, out, N_IN: vector driven to the DUT and golden model; MSB maps to the first DUT input (A).
- `dut_y`, in, N_OUT: DUT response.
- `exp_y`, in, N_OUT: golden-model response.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse when a sweep ends.
- `pass`, out, 1: high when the last completed sweep had zero mismatches.
- `err_count`, out, N_IN+1: number of mismatching vectors in the current or last sweep; saturation is never needed.
- `first_err_vec`, out, N_IN: first mismatching vector; holds 0 when there are no errors.

## Operation
- FSM states:
  - IDLE: `start`=1 → RUN. On entry to RUN, clear `stim`, `hold_cnt`, `err_count`, `first_err_vec` and `pass`.
  - RUN: `hold_cnt` counts 0..HOLD−1.
    - When `hold_cnt`==HOLD−1, compare `dut_y` with `exp_y`. On mismatch, increment `err_count`; if this is the first mismatch, load `first_err_vec`=`stim`.
    - After the compare, if `stim`==2^N_IN−1 → DONE. Otherwise increment `stim` and reset `hold_cnt` to 0.
  - DONE: assert `done` for one cycle, set `pass` = (final `err_count`==0, including the last compare), → IDLE.
- Comparison is full-width equality over N_OUT bits; any bit difference counts as one mismatch for that vector.
- `stim` keeps the final vector after DONE until the next `start`.
- `start` during RUN or DONE is ignored. `start` held high in IDLE starts exactly one sweep per return to IDLE.
- `dut_y` and `exp_y` are sampled synchronously; the earlier HOLD−1 cycles give them time to settle.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_vec`=0, state IDLE.
- `start` sampled at edge k → `busy`=1 and `stim`=0 from edge k+1.
- Each vector is visible for exactly HOLD cycles.
- Full sweep: `busy` is high for 2^N_IN·HOLD cycles. `done` and updated `pass` appear on the cycle after `busy` falls.
- `err_count` and `first_err_vec` update on the edge following the compare cycle.
- Wrap-around: `stim` never wraps. The transition out of 2^N_IN−1 is to DONE, not to 0.
- `rst_n` low mid-sweep returns every output to its reset value immediately, regardless of clock. There is no resume; a new `start` is required.

## Configuration
- `SWEEP_STOP_ON_ERR_EN` defined: the first mismatch compare goes straight to DONE. `err_count`=1, `first_err_vec`=`stim`, `pass`=0, and `stim` stays on the failing vector.
- Undefined: the full sweep always runs and every mismatch is counted.

## Test plan
- N_IN=5, HOLD=10, `dut_y` tied to `exp_y`, pulse `start` → `busy` high for 320 cycles; `stim` steps 0..31 every 10 cycles; `done` pulse; `pass`=1, `err_count`=0.
- Golden model differs only at vector 5'b00011 → `err_count`=1, `first_err_vec`=3, `pass`=0.
- `exp_y`=~`dut_y` always → `err_count`=32, `first_err_vec`=0, `pass`=0.
- `rst_n` low while `stim`=7 → all outputs 0 immediately. A later `start` restarts at `stim`=0 and gives a full 320-cycle sweep.
- `start` pulsed at cycle 50 of RUN → ignored; sweep length stays 320 and only one `done` pulse occurs.
- With `SWEEP_STOP_ON_ERR_EN` and mismatches at vectors 3 and 9 → `done` follows the compare of vector 3 (`busy` high 40 cycles); `stim`=3, `err_count`=1, `first_err_vec`=3.
